// File: rtl/telemetry_rx_pkg.sv
// Shared constants and types for the telemetry receiver slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package telem_pkg;

  // Packet header bytes
  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;

  // Payload bytes following the two-byte header
  localparam int PAY_BYTES = 6;

  // Packet parser state
  typedef enum logic [1:0] {
    PS_HDR1 = 2'd0,
    PS_HDR2 = 2'd1,
    PS_PAY  = 2'd2
  } parseState_t;

  // Byte receiver states (kept as plain constants for legacy tools)
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/telemetry_rx_uart.sv
// 8N1 UART byte receiver with 2-flop input synchronizer and mid-bit sampling.
// Latency: rdy/ferr one clock after the stop-bit sample (~9.5 bit times after start edge).
// Backpressure: none; rx_data holds until the next byte completes.
// Ports: clk/rst_n clock and async active-low reset; RX serial in (idle high);
//        rx_data received byte; rdy good-byte pulse; ferr bad-stop pulse;
//        idle high while waiting for a start edge.
module UART_rx
  import telem_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       ferr,
  output logic       idle
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  logic          rxMeta;
  logic          rxSync;
  logic          rxPrev;
  logic [1:0]    state;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          sampleNow;

  // START waits half a bit to land mid-bit; later states wait a full bit.
  assign sampleNow = (state == RX_START) ? (baudCnt == HALF_LAST)
                                         : (baudCnt == FULL_LAST);
  assign idle    = (state == RX_IDLE);
  assign rx_data = shiftReg;

  // Synchronizer plus one extra flop for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= RX;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      rdy      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rdy  <= 1'b0;
      ferr <= 1'b0;
      if (state == RX_IDLE) begin
        baudCnt <= '0;
        bitCnt  <= '0;
        if (rxPrev && !rxSync) state <= RX_START;
      end else if (!sampleNow) begin
        baudCnt <= baudCnt + 1'b1;
      end else begin
        baudCnt <= '0;
        case (state)
          RX_START: state <= rxSync ? RX_IDLE : RX_DATA;  // high here = glitch
          RX_DATA: begin
            shiftReg <= {rxSync, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= RX_STOP;
          end
          default: begin
            rdy   <= rxSync;
            ferr  <= !rxSync;
            state <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: frames AA 55 + 6 payload bytes into batt/curr/torque.
// Latency: outputs and vld one clock after the last byte's rdy; frm_err one clock after cause.
// Backpressure: none; each new packet overwrites the outputs.
// Ports: clk/rst_n clock and async active-low reset; RX serial in;
//        batt/curr/torque 12-bit readings; vld update pulse; frm_err abort/bad-stop pulse.
module telemetry_rx
  import telem_pkg::*;
#(
  parameter int BAUD_DIV  = 2604,
  parameter int TMO_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err
);

  localparam int TMO_CLKS = TMO_BYTES * 10 * BAUD_DIV;
  localparam int TW = $clog2(TMO_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);
  localparam logic [2:0]    IDX_LAST = 3'(PAY_BYTES - 1);

  logic [7:0]  rxData;
  logic        rxRdy;
  logic        rxFerr;
  logic        rxIdle;

  parseState_t pState;
  logic [2:0]  idx;
  logic [TW-1:0] tmoCnt;
  logic        tmoHit;

  // Shadows hold only the bits that reach the outputs.
  logic [3:0]  shBattHi;
  logic [7:0]  shBattLo;
  logic [3:0]  shCurrHi;
  logic [7:0]  shCurrLo;
  logic [3:0]  shTorqHi;

  UART_rx #(.BAUD_DIV(BAUD_DIV)) uRx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rx_data(rxData),
    .rdy    (rxRdy),
    .ferr   (rxFerr),
    .idle   (rxIdle)
  );

  // A byte completing this cycle beats a coincident timeout.
  assign tmoHit = (pState != PS_HDR1) && rxIdle && (tmoCnt == TMO_LAST)
                  && !rxRdy && !rxFerr;

  // Counts consecutive receiver-idle clocks inside a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmoCnt <= '0;
    end else if (pState == PS_HDR1 || rxRdy || rxFerr || !rxIdle || tmoHit) begin
      tmoCnt <= '0;
    end else begin
      tmoCnt <= tmoCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pState   <= PS_HDR1;
      idx      <= '0;
      shBattHi <= '0;
      shBattLo <= '0;
      shCurrHi <= '0;
      shCurrLo <= '0;
      shTorqHi <= '0;
      batt     <= '0;
      curr     <= '0;
      torque   <= '0;
      vld      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      vld     <= 1'b0;
      frm_err <= 1'b0;
      if (rxFerr || tmoHit) begin
        // Abort: partial shadows are simply overwritten by the next packet.
        frm_err <= 1'b1;
        pState  <= PS_HDR1;
        idx     <= '0;
      end else if (rxRdy) begin
        case (pState)
          PS_HDR1: if (rxData == HDR0) pState <= PS_HDR2;
          PS_HDR2: begin
            if (rxData == HDR1) begin
              pState <= PS_PAY;
              idx    <= '0;
            end else if (rxData != HDR0) begin
              pState <= PS_HDR1;  // a repeated AA may still start a packet
            end
          end
          default: begin
            if (idx == IDX_LAST) begin
              batt   <= {shBattHi, shBattLo};
              curr   <= {shCurrHi, shCurrLo};
              torque <= {shTorqHi, rxData};
              vld    <= 1'b1;
              pState <= PS_HDR1;
              idx    <= '0;
            end else begin
              case (idx)
                3'd0:    shBattHi <= rxData[3:0];
                3'd1:    shBattLo <= rxData;
                3'd2:    shCurrHi <= rxData[3:0];
                3'd3:    shCurrLo <= rxData;
                default: shTorqHi <= rxData[3:0];
              endcase
              idx <= idx + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// Self-checking bench for telemetry_rx: byte-level model plus per-cycle event compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_telemetry_rx;

  localparam int BAUD     = 32;
  localparam int TMOB     = 2;
  localparam int TMO_CLKS = TMOB * 10 * BAUD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX    = 1'b1;
  logic [11:0] batt;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        vld;
  logic        frm_err;

  telemetry_rx #(.BAUD_DIV(BAUD), .TMO_BYTES(TMOB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .batt   (batt),
    .curr   (curr),
    .torque (torque),
    .vld    (vld),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- byte-level reference model ----------------
  typedef struct {
    bit          isErr;
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
  } evt_t;

  evt_t       expQ[$];
  int         mState = 0;   // 0 hunting AA, 1 saw AA, 2 collecting payload
  logic [7:0] mPay[$];
  int         rdyExp = 0;

  task automatic pushErr();
    evt_t e;
    e.isErr = 1'b1; e.b = '0; e.c = '0; e.t = '0;
    expQ.push_back(e);
    mState = 0;
    mPay.delete();
  endtask

  task automatic modelByte(input logic [7:0] d, input bit stopOk);
    evt_t e;
    if (!stopOk) begin
      pushErr();
      return;
    end
    rdyExp++;
    if (mState == 0) begin
      if (d == 8'hAA) mState = 1;
    end else if (mState == 1) begin
      if (d == 8'h55) begin
        mState = 2;
        mPay.delete();
      end else if (d != 8'hAA) begin
        mState = 0;
      end
    end else begin
      mPay.push_back(d);
      if (mPay.size() == 6) begin
        e.isErr = 1'b0;
        e.b = {mPay[0][3:0], mPay[1]};
        e.c = {mPay[2][3:0], mPay[3]};
        e.t = {mPay[4][3:0], mPay[5]};
        expQ.push_back(e);
        mState = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic [7:0] seq[$];

  task automatic sendByte(input logic [7:0] d, input bit stopOk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BAUD) @(negedge clk);
    end
    modelByte(d, stopOk);
    RX = stopOk;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic sendSeq();
    foreach (seq[i]) sendByte(seq[i], 1'b1);
  endtask

  task automatic idleFor(input int clocks);
    if (mState != 0 && clocks >= TMO_CLKS) pushErr();
    RX = 1'b1;
    repeat (clocks) @(negedge clk);
  endtask

  // ---------------- per-cycle compare ----------------
  logic [11:0] pb = '0;
  logic [11:0] pc = '0;
  logic [11:0] pt = '0;
  logic        prevRdy = 1'b0;
  int          vldCnt = 0;
  int          frmCnt = 0;
  int          rdyCnt = 0;
  evt_t        ce;

  always @(negedge clk) begin
    if (!rst_n) begin
      pb = '0; pc = '0; pt = '0;
      prevRdy = 1'b0;
    end else begin
      if (vld || frm_err) begin
        check("vld_frm_err_exclusive", int'(vld && frm_err), 0);
        if (expQ.size() == 0) begin
          check("unexpected_event", int'({vld, frm_err}), 0);
        end else begin
          ce = expQ.pop_front();
          check("event_kind", int'(frm_err), int'(ce.isErr));
          if (vld && !ce.isErr) begin
            check("batt", int'(batt), int'(ce.b));
            check("curr", int'(curr), int'(ce.c));
            check("torque", int'(torque), int'(ce.t));
            check("vld_one_after_rdy", int'(prevRdy), 1);
          end
        end
      end
      if (batt != pb || curr != pc || torque != pt)
        check("out_change_without_vld", int'(vld), 1);
      if (vld) vldCnt++;
      if (frm_err) frmCnt++;
      if (dut.uRx.rdy) rdyCnt++;
      prevRdy = dut.uRx.rdy;
      pb = batt; pc = curr; pt = torque;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, nFails=%0d", nFails);
    $fatal(1, "watchdog expired");
  end

  int v0, f0, r0;

  initial begin
    rst_n = 1'b0;
    RX    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_batt", int'(batt), 0);
    check("rst_curr", int'(curr), 0);
    check("rst_torque", int'(torque), 0);
    check("rst_vld", int'(vld), 0);
    check("rst_frm_err", int'(frm_err), 0);
    rst_n = 1'b1;
    idleFor(2 * BAUD);

    // Basic packet
    v0 = vldCnt; f0 = frmCnt;
    seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    sendSeq();
    idleFor(2 * BAUD);
    check("t1_vld_count", vldCnt - v0, 1);
    check("t1_frm_count", frmCnt - f0, 0);
    check("t1_batt", int'(batt), 'hABC);
    check("t1_curr", int'(curr), 'h123);
    check("t1_torque", int'(torque), 'hFFF);
    check("t1_pending", expQ.size(), 0);

    // Junk prefix and repeated AA before the real header
    v0 = vldCnt;
    seq = '{8'h3A, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
    sendSeq();
    idleFor(2 * BAUD);
    check("t2_vld_count", vldCnt - v0, 1);
    check("t2_batt", int'(batt), 'h011);
    check("t2_curr", int'(curr), 'h022);
    check("t2_torque", int'(torque), 'h033);
    check("t2_pending", expQ.size(), 0);

    // Bad stop bit on payload byte 3
    v0 = vldCnt; f0 = frmCnt;
    seq = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03};
    sendSeq();
    sendByte(8'h04, 1'b0);
    idleFor(4 * BAUD);
    check("t3_frm_count", frmCnt - f0, 1);
    check("t3_vld_count", vldCnt - v0, 0);
    check("t3_batt_kept", int'(batt), 'h011);
    check("t3_torque_kept", int'(torque), 'h033);
    seq = '{8'hAA, 8'h55, 8'h07, 8'h77, 8'h08, 8'h88, 8'h09, 8'h99};
    sendSeq();
    idleFor(2 * BAUD);
    check("t3_recover_batt", int'(batt), 'h777);
    check("t3_recover_curr", int'(curr), 'h888);
    check("t3_recover_torque", int'(torque), 'h999);
    check("t3_pending", expQ.size(), 0);

    // Stall mid-packet for 3 byte-times
    v0 = vldCnt; f0 = frmCnt;
    seq = '{8'hAA, 8'h55, 8'h01, 8'h11, 8'h02};
    sendSeq();
    idleFor(3 * 10 * BAUD);
    check("t4_frm_count", frmCnt - f0, 1);
    check("t4_vld_count", vldCnt - v0, 0);
    check("t4_curr_kept", int'(curr), 'h888);
    seq = '{8'hAA, 8'h55, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h01, 8'h02};
    sendSeq();
    idleFor(2 * BAUD);
    check("t4_batt", int'(batt), 'hC0D);
    check("t4_curr", int'(curr), 'hE0F);
    check("t4_torque", int'(torque), 'h102);
    check("t4_pending", expQ.size(), 0);

    // Short low glitch on idle line
    r0 = rdyCnt; f0 = frmCnt;
    RX = 1'b0;
    repeat (5) @(negedge clk);
    idleFor(3 * BAUD);
    check("t5_glitch_rdy", rdyCnt - r0, 0);
    check("t5_glitch_frm", frmCnt - f0, 0);
    check("rdy_total", rdyCnt, rdyExp);

    // Reset in the middle of a payload byte
    seq = '{8'hAA, 8'h55, 8'h05, 8'h55};
    sendSeq();
    RX = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_batt", int'(batt), 0);
    check("t6_rst_curr", int'(curr), 0);
    check("t6_rst_torque", int'(torque), 0);
    expQ.delete();
    mPay.delete();
    mState = 0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idleFor(2 * BAUD);

    // Two back-to-back packets, no idle between them
    v0 = vldCnt;
    seq = '{8'hAA, 8'h55, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89,
            8'hAA, 8'h55, 8'h0A, 8'hAA, 8'h0B, 8'hBB, 8'h0C, 8'hCC};
    sendSeq();
    idleFor(2 * BAUD);
    check("t6_vld_count", vldCnt - v0, 2);
    check("t6_batt", int'(batt), 'hAAA);
    check("t6_curr", int'(curr), 'hBBB);
    check("t6_torque", int'(torque), 'hCCC);
    check("t6_pending", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
